nb_step_sched: RTL and testbench
================================

NB_STEP_SCHED -- requirements
Module: nb_step_sched

Interface
REQ-001 Parameter: STEPS_W, default 8, width of each requester's step-count field.
REQ-002 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  2  per-requester run request; bit i belongs to requester i.
REQ-005 Port: steps0  input  STEPS_W  step count for requester 0, sampled at grant.
REQ-006 Port: steps1  input  STEPS_W  step count for requester 1, sampled at grant.
REQ-007 Port: gnt  output  2  one-hot, registered, one-cycle grant pulse.
REQ-008 Port: busy  output  1  high while state is RUN.
REQ-009 Port: done  output  1  one-cycle completion pulse; high while state is DONE.
REQ-010 Port: owner  output  1  index of the currently or last granted requester.
REQ-011 Port: a, b, c, d  output  32 each  datapath registers.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE, with outputs decoded from state (Moore).
REQ-013 IDLE with req==0 SHALL hold state and all registers.
REQ-014 IDLE with req!=0 SHALL select a winner, pulse gnt, set owner, and latch that requester's steps into cnt at the same edge.
- Next state is RUN, or DONE when the latched steps==0.
REQ-015 Arbitration SHALL be round-robin.
- A single requester always wins.
- With req==2'b11, the winner is the requester other than the last-granted one.
- The pointer resets to "last=1", so requester 0 wins first.
REQ-016 Each RUN edge SHALL apply one parallel update using pre-edge values, and decrement cnt:
- a<=b+c
- d<=a-3
- b<=d+10
- c<=c+1
REQ-017 All arithmetic SHALL be unsigned modulo 2^32; carries are discarded and a-3 wraps when a<3.
REQ-018 RUN with cnt==1 SHALL apply the final update and go to DONE.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-020 Timing for N steps: grant edge E0, updates at edges E1..EN, done high in the cycle after EN, next grant no earlier than edge EN+2.
REQ-021 A zero-step grant SHALL produce a gnt pulse, then a done pulse in the following cycle, with no register update.
REQ-022 req SHALL be ignored outside IDLE.
- A requester holds req until its gnt.
- Dropping req before gnt withdraws the request without side effects.
REQ-023 steps0/steps1 changes after the grant edge SHALL not affect the active run.

Reset
REQ-024 Reset SHALL take effect at the next rising clock edge and SHALL override all other activity, including a run in progress.
REQ-025 Reset SHALL set: a=30, b=20, c=15, d=5, state=IDLE, cnt=0, gnt=0, done=0, busy=0, owner=0, round-robin pointer=1.

Configuration
REQ-026 Macro NB_SCHED_ABORT_EN defined SHALL add port abort (input, 1 bit).
- abort high on a RUN edge suppresses that edge's update and forces DONE.
- done pulses normally; registers keep their pre-abort values.
- abort is ignored in IDLE and DONE.
REQ-027 Macro NB_SCHED_ABORT_EN undefined SHALL omit the abort port; RUN always completes cnt steps.

Verification
REQ-028 Reset held 2 cycles -> a=30, b=20, c=15, d=5; busy=0, done=0, gnt=0.
REQ-029 req=01, steps0=1 after reset -> gnt=01 for one cycle; after 1 update a=35, b=15, c=16, d=27; done pulses once; owner=0.
REQ-030 req=01, steps0=2 from reset -> a=31, b=37, c=17, d=32; busy high exactly 2 cycles.
REQ-031 req=11 held, steps0=steps1=1 -> grants are 01 then 10 then 01, each followed by its done pulse.
REQ-032 Zero-step case and reset mid-run:
- req=10, steps1=0 -> gnt=10, done next cycle, registers unchanged.
- Reset asserted mid-run with steps0=5 -> reset values of REQ-025 restored, state IDLE.
REQ-033 With NB_SCHED_ABORT_EN: steps0=4, abort on the 2nd RUN edge -> exactly 1 update applied (a=35, b=15, c=16, d=27), done pulses.

Source files
------------

// File: rtl/nb_step_sched.sv
// nb_step_sched: two-requester round-robin step scheduler.
//
// A requester raises req[i]; in IDLE the round-robin arbiter picks a winner,
// pulses gnt for one cycle, records owner and latches that requester's step
// count. Each RUN cycle applies one parallel update to the datapath
// registers a..d and decrements the count; the last update moves to DONE,
// which lasts one cycle before returning to IDLE.
//
// Parameters:
//   STEPS_W  width of the per-requester step-count fields
// Ports:
//   clock         single rising-edge clock
//   reset         synchronous active-high reset
//   req[1:0]      run request per requester (sampled only in IDLE)
//   steps0/1      step count per requester, sampled at grant
//   abort         (only with NB_SCHED_ABORT_EN) cancel the run, skip update
//   gnt[1:0]      one-hot one-cycle grant pulse (registered)
//   busy          high while in RUN
//   done          high for the single DONE cycle
//   owner         index of the current or last granted requester
//   a, b, c, d    32-bit datapath registers
// Configuration macro:
//   NB_SCHED_ABORT_EN  adds the abort input
module nb_step_sched #(
   parameter int unsigned STEPS_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [1:0]         req,
   input  logic [STEPS_W-1:0] steps0,
   input  logic [STEPS_W-1:0] steps1,
`ifdef NB_SCHED_ABORT_EN
   input  logic               abort,
`endif
   output logic [1:0]         gnt,
   output logic               busy,
   output logic               done,
   output logic               owner,
   output logic [31:0]        a,
   output logic [31:0]        b,
   output logic [31:0]        c,
   output logic [31:0]        d
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_t;

   state_t             state;
   logic [STEPS_W-1:0] cnt;
   logic               last;      // round-robin pointer: last granted requester
   logic               win;
   logic [STEPS_W-1:0] win_steps;
   logic               abort_hit;

`ifdef NB_SCHED_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // Contended request goes to the requester that was not granted last.
   always_comb begin
      win = 1'b0;
      if (req == 2'b11) begin
         win = ~last;
      end else begin
         win = req[1];
      end
      win_steps = win ? steps1 : steps0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= StIdle;
         cnt   <= '0;
         gnt   <= 2'b00;
         owner <= 1'b0;
         last  <= 1'b1;
         a     <= 32'd30;
         b     <= 32'd20;
         c     <= 32'd15;
         d     <= 32'd5;
      end else begin
         gnt <= 2'b00;
         case (state)
            StIdle: begin
               if (req != 2'b00) begin
                  gnt   <= win ? 2'b10 : 2'b01;
                  owner <= win;
                  last  <= win;
                  cnt   <= win_steps;
                  state <= (win_steps == '0) ? StDone : StRun;
               end
            end
            StRun: begin
               if (abort_hit) begin
                  state <= StDone;
               end else begin
                  // All right-hand sides use pre-edge values.
                  a   <= b + c;
                  d   <= a - 32'd3;
                  b   <= d + 32'd10;
                  c   <= c + 32'd1;
                  cnt <= cnt - STEPS_W'(1);
                  if (cnt == STEPS_W'(1)) begin
                     state <= StDone;
                  end
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   assign busy = (state == StRun);
   assign done = (state == StDone);

endmodule

// File: tb/tb_nb_step_sched.sv
// Self-checking bench for nb_step_sched: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_nb_step_sched;
   localparam int unsigned STEPS_W = 8;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic [1:0]         req = 2'b00;
   logic [STEPS_W-1:0] steps0 = '0;
   logic [STEPS_W-1:0] steps1 = '0;
`ifdef NB_SCHED_ABORT_EN
   logic               abort = 1'b0;
`endif
   logic [1:0]         gnt;
   logic               busy;
   logic               done;
   logic               owner;
   logic [31:0]        a, b, c, d;

   int checks = 0;
   int errors = 0;

   // Model state: register values, round-robin pointer, owner.
   logic [31:0] ma, mb, mc, md;
   logic        mlast;
   logic        mowner;

   nb_step_sched #(.STEPS_W(STEPS_W)) dut (
      .clock  (clock),
      .reset  (reset),
      .req    (req),
      .steps0 (steps0),
      .steps1 (steps1),
`ifdef NB_SCHED_ABORT_EN
      .abort  (abort),
`endif
      .gnt    (gnt),
      .busy   (busy),
      .done   (done),
      .owner  (owner),
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ma = 32'd30; mb = 32'd20; mc = 32'd15; md = 32'd5;
      mlast = 1'b1; mowner = 1'b0;
   endtask

   // n parallel updates, each computed from the previous step's values.
   task automatic model_run(input int n);
      logic [31:0] ta, tb, tc, td;
      for (int i = 0; i < n; i++) begin
         ta = mb + mc;
         td = ma - 32'd3;
         tb = md + 32'd10;
         tc = mc + 32'd1;
         ma = ta; mb = tb; mc = tc; md = td;
      end
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_a"}, a, ma);
      chk({tag, "_b"}, b, mb);
      chk({tag, "_c"}, c, mc);
      chk({tag, "_d"}, d, md);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 2'b00;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      check_regs("rst");
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
   endtask

   // One complete transaction starting from IDLE at a negedge.
   task automatic run_txn(input logic [1:0] r, input logic [7:0] s0, input logic [7:0] s1,
                          input bit hold);
      logic w;
      int   n;
      int   cyc;
      req = r; steps0 = s0; steps1 = s1;
      if (r == 2'b01)      w = 1'b0;
      else if (r == 2'b10) w = 1'b1;
      else                 w = ~mlast;
      n = w ? int'(s1) : int'(s0);
      @(posedge clock);
      @(negedge clock);
      chk("gnt", 32'(gnt), w ? 32'd2 : 32'd1);
      chk("owner", 32'(owner), 32'(w));
      mlast = w; mowner = w;
      // Step inputs after grant must not matter.
      steps0 = 8'($urandom); steps1 = 8'($urandom);
      if (!hold) req = 2'b00;
      if (n == 0) begin
         chk("zero_busy", 32'(busy), 32'd0);
         chk("zero_done", 32'(done), 32'd1);
      end else begin
         chk("run_busy", 32'(busy), 32'd1);
         chk("run_done", 32'(done), 32'd0);
         cyc = 0;
         while (busy === 1'b1 && cyc < 1000) begin
            cyc++;
            if (!hold) req = 2'($urandom_range(0, 3));
            @(posedge clock);
            @(negedge clock);
            if (cyc == 1) chk("gnt_pulse", 32'(gnt), 32'd0);
         end
         chk("busy_cycles", 32'(cyc), 32'(n));
         chk("end_done", 32'(done), 32'd1);
         if (!hold) req = 2'b00;
         model_run(n);
      end
      check_regs("run");
      chk("owner_kept", 32'(owner), 32'(mowner));
      @(posedge clock);
      @(negedge clock);
      chk("post_done", 32'(done), 32'd0);
      chk("post_gnt", 32'(gnt), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      model_reset();
      @(negedge clock);
      do_reset();

      // Single step from requester 0.
      run_txn(2'b01, 8'd1, 8'd0, 1'b0);
      chk("s1_a", a, 32'd35);
      chk("s1_b", b, 32'd15);
      chk("s1_c", c, 32'd16);
      chk("s1_d", d, 32'd27);
      chk("s1_owner", 32'(owner), 32'd0);

      // Two steps from reset.
      do_reset();
      run_txn(2'b01, 8'd2, 8'd0, 1'b0);
      chk("s2_a", a, 32'd31);
      chk("s2_b", b, 32'd37);
      chk("s2_c", c, 32'd17);
      chk("s2_d", d, 32'd32);

      // Held contention alternates 01, 10, 01.
      do_reset();
      run_txn(2'b11, 8'd1, 8'd1, 1'b1);
      run_txn(2'b11, 8'd1, 8'd1, 1'b1);
      run_txn(2'b11, 8'd1, 8'd1, 1'b1);
      req = 2'b00;

      // Zero-step grant to requester 1.
      run_txn(2'b10, 8'd0, 8'd0, 1'b0);

      // Reset in the middle of a 5-step run.
      req = 2'b01; steps0 = 8'd5;
      @(posedge clock);
      @(negedge clock);
      chk("mr_gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      repeat (2) begin
         @(posedge clock);
         @(negedge clock);
      end
      chk("mr_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      check_regs("mr");
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      chk("mr_owner", 32'(owner), 32'd0);
      // Pointer back to last=1: requester 0 wins contention first.
      run_txn(2'b11, 8'd0, 8'd0, 1'b0);

`ifdef NB_SCHED_ABORT_EN
      do_reset();
      req = 2'b01; steps0 = 8'd4;
      @(posedge clock);
      @(negedge clock);
      chk("ab_gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      @(posedge clock);
      @(negedge clock);
      abort = 1'b1;
      @(posedge clock);
      @(negedge clock);
      abort = 1'b0;
      chk("ab_done", 32'(done), 32'd1);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_a", a, 32'd35);
      chk("ab_b", b, 32'd15);
      chk("ab_c", c, 32'd16);
      chk("ab_d", d, 32'd27);
      @(posedge clock);
      @(negedge clock);
      chk("ab_post_done", 32'(done), 32'd0);
      model_reset();
      model_run(1);
      mlast = 1'b0; mowner = 1'b0;
`endif

      // Randomized transactions.
      for (int i = 0; i < 25; i++) begin
         run_txn(2'($urandom_range(1, 3)), 8'($urandom_range(0, 6)),
                 8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
         req = 2'b00;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
